// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing controller.
//   - Default 640x480@60 timing constants (pixels / lines).
//   - h_phase_t: horizontal scan phase enum.
//   - cw_for(): counter width wide enough for the larger of the two totals.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_SYNC_ACT = 1'b0;

    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FP  = 2'd1,
        H_SYN = 2'd2,
        H_BP  = 2'd3
    } h_phase_t;

    // Counters run 0..total-1, so $clog2(total) bits always suffice.
    function automatic int cw_for(input int h_total, input int v_total);
        return $clog2((h_total > v_total) ? h_total : v_total);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_strobe.sv
// Divide-by-2 pixel strobe on the board clock.
//   clk_50m : board clock
//   rst     : synchronous, active-high reset (strobe forced low)
//   stb     : registered strobe, high every second clk_50m cycle;
//             the first edge after reset release drives it high.
module pix_strobe (
    input  logic clk_50m,
    input  logic rst,
    output logic stb
);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            stb <= 1'b0;
        end else begin
            stb <= ~stb;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Display timing controller (default 640x480@60) on the 50 MHz board clock.
// The scan advances on cycles where the registered pixel strobe is high.
//   clk_50m     : board clock, sole clock
//   rst         : synchronous, active-high reset
//   pix_stb     : pixel strobe (every second clk_50m cycle)
//   sx, sy      : horizontal / vertical scan counters
//   de          : data enable, high inside the visible area
//   hsync/vsync : sync outputs, asserted level = SYNC_ACT
//   line_start  : one-cycle pulse when sx=0 is first presented
//   frame_start : one-cycle pulse when (0,0) is first presented
//   dbg_h_phase : current horizontal phase FSM state
// All outputs are registered; de/hsync/vsync are decoded from the next
// counter/phase values so they line up with sx/sy.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_ACT = VGA_SYNC_ACT,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int CW      = cw_for(H_TOTAL, V_TOTAL)
) (
    input  logic                clk_50m,
    input  logic                rst,
    output logic                pix_stb,
    output logic [CW-1:0]       sx,
    output logic [CW-1:0]       sy,
    output logic                de,
    output logic                hsync,
    output logic                vsync,
    output logic                line_start,
    output logic                frame_start,
    output vga_pkg::h_phase_t   dbg_h_phase
);

    // Enum literals are package-qualified: the parameters H_FP/H_BP shadow them.
    localparam logic [CW-1:0] SX_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] SY_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] SX_ACT_END = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] SX_FP_END  = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] SX_SYN_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] SY_ACT     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] SY_VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] SY_VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    vga_pkg::h_phase_t phase;
    vga_pkg::h_phase_t phase_nxt;
    logic [CW-1:0]     sx_nxt;
    logic [CW-1:0]     sy_nxt;
    logic              adv;
    logic              wrap_x;
    logic              wrap_y;

    pix_strobe u_pix_strobe (
        .clk_50m (clk_50m),
        .rst     (rst),
        .stb     (pix_stb)
    );

    assign adv         = pix_stb;
    assign wrap_x      = (sx == SX_LAST);
    assign wrap_y      = (sy == SY_LAST);
    assign dbg_h_phase = phase;

    // Next counter values and horizontal phase. Phase transitions are keyed
    // on the current sx, so the phase always describes the pixel in sx_nxt.
    always_comb begin
        sx_nxt    = sx;
        sy_nxt    = sy;
        phase_nxt = phase;
        if (adv) begin
            if (wrap_x) begin
                sx_nxt = '0;
                sy_nxt = wrap_y ? '0 : sy + 1'b1;
            end else begin
                sx_nxt = sx + 1'b1;
            end
            case (phase)
                vga_pkg::H_ACT: if (sx == SX_ACT_END) phase_nxt = vga_pkg::H_FP;
                vga_pkg::H_FP:  if (sx == SX_FP_END)  phase_nxt = vga_pkg::H_SYN;
                vga_pkg::H_SYN: if (sx == SX_SYN_END) phase_nxt = vga_pkg::H_BP;
                vga_pkg::H_BP:  if (wrap_x)           phase_nxt = vga_pkg::H_ACT;
                default:                              phase_nxt = vga_pkg::H_BP;
            endcase
        end
    end

    // Reset parks the scan on the last back-porch pixel of the last line,
    // so the first advance lands on (0,0) and raises both start pulses.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            phase       <= vga_pkg::H_BP;
            sx          <= SX_LAST;
            sy          <= SY_LAST;
            de          <= 1'b0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            sx          <= sx_nxt;
            sy          <= sy_nxt;
            de          <= (phase_nxt == vga_pkg::H_ACT) && (sy_nxt < SY_ACT);
            hsync       <= (phase_nxt == vga_pkg::H_SYN) ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= ((sy_nxt >= SY_VS_BEG) && (sy_nxt <= SY_VS_END)) ?
                           SYNC_ACT : ~SYNC_ACT;
            line_start  <= adv && wrap_x;
            frame_start <= adv && wrap_x && wrap_y;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 instance (A) and a small
// active-high-sync instance (B), both with random reset pulses, compared
// every cycle against an elapsed-cycle arithmetic model.
module tb_vga_timing_ctrl;

    // ---------------- clock / reset ----------------
    logic clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    // ---------------- DUT A: default timing ----------------
    logic              pix_stb_a, de_a, hsync_a, vsync_a, line_start_a, frame_start_a;
    logic [9:0]        sx_a, sy_a;
    vga_pkg::h_phase_t dbg_a;

    vga_timing_ctrl u_dut_a (
        .clk_50m     (clk_50m),
        .rst         (rst_a),
        .pix_stb     (pix_stb_a),
        .sx          (sx_a),
        .sy          (sy_a),
        .de          (de_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a),
        .dbg_h_phase (dbg_a)
    );

    // ---------------- DUT B: small timing, active-high sync ----------------
    logic              pix_stb_b, de_b, hsync_b, vsync_b, line_start_b, frame_start_b;
    logic [3:0]        sx_b, sy_b;
    vga_pkg::h_phase_t dbg_b;

    vga_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_ACT (1'b1)
    ) u_dut_b (
        .clk_50m     (clk_50m),
        .rst         (rst_b),
        .pix_stb     (pix_stb_b),
        .sx          (sx_b),
        .sy          (sy_b),
        .de          (de_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b),
        .dbg_h_phase (dbg_b)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    int          k_a = 0;
    int          k_b = 0;
    bit          done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Layout: [27:26] phase [25] pix_stb [24] de [23] hsync [22] vsync
    //         [21] line_start [20] frame_start [19:10] sx [9:0] sy
    function automatic logic [31:0] pack(input logic [1:0] ph, input logic p, input logic d,
                                         input logic h, input logic v, input logic l,
                                         input logic f, input logic [9:0] x, input logic [9:0] y);
        return {4'b0, ph, p, d, h, v, l, f, x, y};
    endfunction

    // k = clock edges since reset was last sampled low (0 = in reset).
    // Advances happen on every even edge; the n-th advance shows scan
    // position n-1 counting from (0,0), the park position being "-1".
    function automatic logic [31:0] ref_outs(input int k, input int ha, input int hf, input int hs,
                                             input int hb, input int va, input int vf, input int vs,
                                             input int vb, input bit sact);
        int ht, vt, pos, x, y;
        logic [1:0] ph;
        logic p, d, h, v, l, f;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        pos = ((k / 2) + ht * vt - 1) % (ht * vt);
        x   = pos % ht;
        y   = pos / ht;
        p   = (k % 2) == 1;
        d   = (x < ha) && (y < va);
        h   = ((x >= ha + hf) && (x < ha + hf + hs)) ? sact : !sact;
        v   = ((y >= va + vf) && (y < va + vf + vs)) ? sact : !sact;
        l   = (k > 0) && (k % 2 == 0) && (x == 0);
        f   = l && (y == 0);
        if (x < ha)                ph = vga_pkg::H_ACT;
        else if (x < ha + hf)      ph = vga_pkg::H_FP;
        else if (x < ha + hf + hs) ph = vga_pkg::H_SYN;
        else                       ph = vga_pkg::H_BP;
        return pack(ph, p, d, h, v, l, f, 10'(x), 10'(y));
    endfunction

    always @(posedge clk_50m) begin
        k_a = rst_a ? 0 : k_a + 1;
        k_b = rst_b ? 0 : k_b + 1;
        exp_q_a.push_back(ref_outs(k_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        exp_q_b.push_back(ref_outs(k_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
    end

    always @(negedge clk_50m) begin
        if (exp_q_a.size() != 0)
            check("a_outs", pack(dbg_a, pix_stb_a, de_a, hsync_a, vsync_a, line_start_a,
                                 frame_start_a, sx_a, sy_a), exp_q_a.pop_front());
        if (exp_q_b.size() != 0)
            check("b_outs", pack(dbg_b, pix_stb_b, de_b, hsync_b, vsync_b, line_start_b,
                                 frame_start_b, {6'b0, sx_b}, {6'b0, sy_b}), exp_q_b.pop_front());
    end

    // ---------------- driver tasks ----------------
    task automatic wait_sx_a(input int target);
        int c;
        c = 0;
        while (int'(sx_a) != target && c < 4000) begin
            @(negedge clk_50m);
            c++;
        end
        check("a_wait_sx", 32'(c < 4000), 32'd1);
    endtask

    // Called at the negedge right after rst_a is released.
    task automatic a_restart_checks();
        @(negedge clk_50m);
        check("a_stb_first", 32'(pix_stb_a), 32'd1);
        check("a_sx_parked", 32'(sx_a), 32'd799);
        @(negedge clk_50m);
        check("a_sx_origin", 32'(sx_a), 32'd0);
        check("a_sy_origin", 32'(sy_a), 32'd0);
        check("a_de_origin", 32'(de_a), 32'd1);
        check("a_fs_origin", 32'(frame_start_a), 32'd1);
        check("a_ls_origin", 32'(line_start_a), 32'd1);
        @(negedge clk_50m);
        check("a_fs_drop", 32'(frame_start_a), 32'd0);
        check("a_ls_drop", 32'(line_start_a), 32'd0);
    endtask

    // ---------------- stimulus A ----------------
    initial begin
        int c;
        repeat (5) @(negedge clk_50m);
        check("a_reset_sx", 32'(sx_a), 32'd799);
        check("a_reset_sy", 32'(sy_a), 32'd524);
        check("a_reset_hs", 32'(hsync_a), 32'd1);
        rst_a = 1'b0;
        a_restart_checks();

        // Line period: next line_start 1600 cycles after the one at (0,0).
        c = 1;
        do begin
            @(negedge clk_50m);
            c++;
        end while (!line_start_a && c < 2000);
        check("a_line_period", 32'(c), 32'd1600);

        wait_sx_a(639); check("a_de_639", 32'(de_a), 32'd1);
        wait_sx_a(640); check("a_de_640", 32'(de_a), 32'd0);
        wait_sx_a(655); check("a_hs_655", 32'(hsync_a), 32'd1);
        wait_sx_a(656); check("a_hs_656", 32'(hsync_a), 32'd0);
        wait_sx_a(751); check("a_hs_751", 32'(hsync_a), 32'd0);
        wait_sx_a(752); check("a_hs_752", 32'(hsync_a), 32'd1);

        // Reset inside the hsync pulse.
        wait_sx_a(700);
        rst_a = 1'b1;
        @(negedge clk_50m);
        check("a_rst_hs", 32'(hsync_a), 32'd1);
        check("a_rst_sx", 32'(sx_a), 32'd799);
        check("a_rst_sy", 32'(sy_a), 32'd524);
        check("a_rst_de", 32'(de_a), 32'd0);
        repeat (4) @(negedge clk_50m);
        rst_a = 1'b0;
        a_restart_checks();

        // Random reset pulses at arbitrary strobe phases.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(20, 3000)) @(negedge clk_50m);
            rst_a = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk_50m);
            rst_a = 1'b0;
        end
        repeat (2000) @(negedge clk_50m);
        done = 1'b1;
        repeat (2) @(negedge clk_50m);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus B ----------------
    initial begin
        int c;
        repeat (3) @(negedge clk_50m);
        rst_b = 1'b0;
        c = 0;
        while (!frame_start_b && c < 400) begin
            @(negedge clk_50m);
            c++;
        end
        check("b_first_frame", 32'(c < 400), 32'd1);
        c = 0;
        do begin
            @(negedge clk_50m);
            c++;
        end while (!frame_start_b && c < 400);
        check("b_frame_period", 32'(c), 32'd196);
        while (!done) begin
            repeat ($urandom_range(10, 600)) @(negedge clk_50m);
            rst_b = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk_50m);
            rst_b = 1'b0;
        end
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Display timing controller for the 640x480@60 output path. Runs entirely on the 50 MHz board clock and produces a divide-by-2 pixel strobe instead of a derived 25 MHz clock. Sequences the horizontal and vertical scan counters, and generates hsync, vsync, data-enable, pixel coordinates and frame/line markers for the downstream pixel generator and DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACT, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk_50m  input  1  board clock, 50 MHz, sole clock
rst  input  1  synchronous, active-high reset
pix_stb  output  1  pixel strobe, high every second clk_50m cycle
sx  output  CW  horizontal counter, 0..H_TOTAL-1
sy  output  CW  vertical counter, 0..V_TOTAL-1
de  output  1  high while sx<H_ACTIVE and sy<V_ACTIVE
hsync  output  1  horizontal sync, level per SYNC_ACT
vsync  output  1  vertical sync, level per SYNC_ACT
line_start  output  1  one clk_50m pulse when sx becomes 0
frame_start  output  1  one clk_50m pulse when sx and sy both become 0

Behaviour:
- Interface (decided): one clock, clk_50m. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk_50m.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); CW = $clog2(max(H_TOTAL,V_TOTAL)) (10).
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values: pix_stb=0, sx=H_TOTAL-1 (799), sy=V_TOTAL-1 (524), de=0, hsync=vsync=~SYNC_ACT, line_start=0, frame_start=0.
- Reset parks the scan on the last back-porch pixel, so the first advance lands on (0,0).
- pix_stb toggles on every clk_50m edge while rst=0. The first edge after reset release sets it to 1.
- Advance rule: on an edge where registered pix_stb=1:
  - sx increments.
  - At H_TOTAL-1, sx wraps to 0 and sy increments.
  - At V_TOTAL-1, sy wraps to 0.
- Counters hold on edges where pix_stb=0.
- de, hsync and vsync are registered decodes of the next counter values, so they stay aligned with sx/sy (zero relative latency).
- hsync is asserted for sx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- vsync is asserted for sy in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]. vsync changes only at the sx wrap.
- line_start is 1 for exactly the clk_50m cycle in which sx=0 is first presented.
- frame_start is 1 for exactly the cycle in which (0,0) is first presented; line_start is also high in that cycle.
- Horizontal phase FSM (kept in parallel with sx, used for the hsync/de decode):
  - H_ACT -> H_FP at sx=H_ACTIVE-1
  - H_FP -> H_SYN at sx=H_ACTIVE+H_FP-1
  - H_SYN -> H_BP at the sync end
  - H_BP -> H_ACT at the wrap
  - Reset state is H_BP.
- Reset mid-frame: on the next edge, all outputs return to their reset values regardless of phase. No partial sync pulse continues.
- rst asserted on a pix_stb=1 edge: reset wins and no advance occurs.
- Frame period: H_TOTAL*V_TOTAL*2 = 840000 clk_50m cycles.

Decomposition:
- Package vga_pkg:
  - Default timing constants for 640x480@60.
  - Enum h_phase_t {H_ACT, H_FP, H_SYN, H_BP}.
  - Helper function for CW.
- Sub-module pix_strobe: enable-style divide-by-2 on clk_50m/rst. Outputs a 1-cycle-wide strobe instead of a divided clock.

Test Plan:
- Reset held 5 cycles, then released -> pix_stb=1 on the 1st edge. On the 2nd edge, sx=0, sy=0, de=1, frame_start=1, line_start=1; both pulses drop the next cycle.
- Free-run one line -> sx advances every 2 clk_50m cycles. de falls when sx=640. hsync goes low at sx=656 and high at sx=752. Line period is 1600 cycles.
- Free-run a full frame -> vsync is low for exactly sy=490..491 (3200 cycles). de=0 for sy>=480. frame_start recurs after exactly 840000 cycles.
- Wrap check -> from (799,524), the next advance gives (0,0). From (799,100), it gives (0,101) with line_start=1 and frame_start=0.
- Reset asserted at sx=700 inside hsync -> the next edge shows hsync=1, sx=799, sy=524, de=0. Restart matches the first scenario.
- Parameter override SYNC_ACT=1 with small timings (H 8/2/2/2, V 4/1/1/1) -> hsync is high only at sx=10..11 and vsync high only at sy=5. Frame is 14*7*2 = 196 cycles.
